param_inout_port: RTL
=====================

# param_inout_port

Parametrised bidirectional bus port for FPGA pins shared with an external device. It generalises the registered inout buffer with:
- a configurable input synchroniser depth,
- a write transaction that drives the pin for a fixed hold time, then enforces a bus-release turnaround,
- a read transaction that returns a deterministic sample with a valid pulse.

It sits between core logic (Avalon/Qsys side) and top-level tristate pins.

## Interface
- DATA_WIDTH, 8, bus width; ≥1
- SYNC_STAGES, 2, input synchroniser flops; ≥1
- HOLD_CYCLES, 1, cycles the pin is driven per write; ≥1
- TURN_CYCLES, 1, released-bus guard cycles after a write; ≥0

Ports:
- clk  input  1  single clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- ioDATA  inout  DATA_WIDTH  shared pin bus
- iWR  input  1  write request, sampled on clk
- iWDATA  input  DATA_WIDTH  write data, latched when iWR is accepted
- iRD  input  1  read request, sampled on clk
- oRDATA  output  DATA_WIDTH  captured read data
- oRVALID  output  1  one-cycle pulse, oRDATA valid
- oBUSY  output  1  transaction in progress; requests ignored
- oOE  output  1  registered drive enable (1 = pin driven)
- oSYNC  output  DATA_WIDTH  free-running synchronised pin value (last sync stage)

## Operation
States:
- **IDLE**: bus released; oBUSY = 0.
- **DRIVE**: ioDATA = latched write data from a register; oOE = 1.
- **TURN**: bus released; guard interval.
- **READ**: waiting for the synchroniser to flush.

Transitions:
- IDLE + iWR → DRIVE; the iWDATA value is latched and held for all of DRIVE. Later changes to iWDATA are ignored.
- IDLE + iRD (iWR low) → READ.
- iWR and iRD both high in IDLE: the write wins. The read is dropped, not queued.
- DRIVE → TURN after HOLD_CYCLES cycles. If TURN_CYCLES = 0, DRIVE → IDLE directly.
- TURN → IDLE after TURN_CYCLES cycles.
- READ → IDLE after SYNC_STAGES cycles. On that transition edge:
  - oRDATA is loaded from the last sync stage;
  - oRVALID is 1 for one cycle.
- iWR and iRD are ignored whenever oBUSY = 1. No queueing and no error flag.

Datapath rules:
- oBUSY = (state != IDLE), from registered state.
- ioDATA = oOE ? drive register : all-Z. No combinational path from iWR or iWDATA to the pin.
- Synchroniser: stage 1 samples ioDATA every edge, including while this block drives the pin. oSYNC always reflects the pin.
- Hold and turn counters are sized $clog2(max(HOLD_CYCLES, TURN_CYCLES, SYNC_STAGES)+1). They count down to 0 and have no wrap-around.

## Timing
- Write accepted at edge N:
  - oOE = 1 and the pin is driven from edge N to edge N+HOLD_CYCLES;
  - the pin is released at edge N+HOLD_CYCLES;
  - oBUSY falls at edge N+HOLD_CYCLES+TURN_CYCLES, and a new request is accepted on that same edge.
  - oBUSY is high for exactly HOLD_CYCLES+TURN_CYCLES cycles.
- Read accepted at edge N:
  - at edge N+SYNC_STAGES, oRDATA = the value ioDATA had when sampled at edge N;
  - oRVALID is high for the following cycle;
  - oBUSY falls on the same edge.
  - Back-to-back reads: one every SYNC_STAGES cycles.
- oSYNC latency: the pin is sampled at edge k and appears on oSYNC after edge k+SYNC_STAGES−1.
- Reset (rst high at an edge), from that edge:
  - state = IDLE; oOE = 0, so the pin goes Z immediately;
  - oBUSY = 0, oRVALID = 0, oRDATA = 0;
  - sync chain = 0, so oSYNC = 0;
  - counters = 0.
- Reset mid-DRIVE releases the bus with no TURN. Reset mid-READ produces no oRVALID.
- Requests are ignored while rst is high. The first accept is possible at the first edge with rst low.

## Test plan
- Reset: drive rst for 2 cycles with the pin externally at 8'hA5 → oOE = 0, pin Z from this block, oSYNC/oRDATA/oRVALID/oBUSY = 0. oSYNC shows 8'hA5 SYNC_STAGES cycles after rst falls.
- Write, defaults: iWR with iWDATA = 8'h3C at edge N, then iWDATA changed to 8'hFF at N+1 →
  - pin = 8'h3C for 1 cycle only, then Z;
  - oBUSY high for 2 cycles;
  - a second iWR at N+1 is ignored; one at N+2 is accepted.
- Read, SYNC_STAGES = 3: external 8'h5A at edge N, changed to 8'h00 at N+1, iRD at N → oRDATA = 8'h5A and oRVALID pulses after edge N+3. A second iRD at N+3 returns 8'h00.
- Collision: iWR = iRD = 1 in IDLE → write performed, no oRVALID ever. With TURN_CYCLES = 0, HOLD_CYCLES = 4: oBUSY high for 4 cycles and the pin is released immediately after.
- Reset mid-transaction: rst at the 2nd DRIVE cycle (HOLD_CYCLES = 4) → pin Z at that edge, no TURN. rst mid-READ → no oRVALID pulse, oRDATA stays 0.
- Width sweep: DATA_WIDTH = 1 and 32 with walking-ones write/read loopback via an external keeper model → every read matches the last external value, and oOE never overlaps the external driver window.

Source files
------------

// File: rtl/param_inout_port.sv
// Registered bidirectional pin port: timed write drive followed by a bus-release guard,
// and synchronised read sampling that returns one captured word with a one-cycle valid pulse.
module param_inout_port #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] ioDATA,
  input  logic                  iWR,
  input  logic [DATA_WIDTH-1:0] iWDATA,
  input  logic                  iRD,
  output logic [DATA_WIDTH-1:0] oRDATA,
  output logic                  oRVALID,
  output logic                  oBUSY,
  output logic                  oOE,
  output logic [DATA_WIDTH-1:0] oSYNC
);

  localparam int unsigned MaxHt  = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int unsigned MaxCnt = (MaxHt > SYNC_STAGES) ? MaxHt : SYNC_STAGES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] TurnLoad = CntW'((TURN_CYCLES == 0) ? 0 : TURN_CYCLES - 1);
  localparam logic [CntW-1:0] SyncLoad = CntW'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StTurn,
    StRead
  } state_e;

  state_e                                 state_q, state_d;
  logic [CntW-1:0]                        cnt_q, cnt_d;
  logic                                   oe_q, oe_d;
  logic [DATA_WIDTH-1:0]                  drive_q, drive_d;
  logic [DATA_WIDTH-1:0]                  rdata_q, rdata_d;
  logic                                   rvalid_q, rvalid_d;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic                                   accept_ok;

  // Stage 0 samples the pin every edge, even while this block is the driver.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = ioDATA;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    oe_d      = oe_q;
    drive_d   = drive_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    accept_ok = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept_ok = 1'b1;
      end
      StDrive: begin
        if (cnt_q == '0) begin
          oe_d = 1'b0;
          if (TURN_CYCLES == 0) begin
            state_d   = StIdle;
            accept_ok = 1'b1;
          end else begin
            state_d = StTurn;
            cnt_d   = TurnLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StTurn: begin
        if (cnt_q == '0) begin
          state_d   = StIdle;
          accept_ok = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRead: begin
        if (cnt_q == '0) begin
          state_d   = StIdle;
          rdata_d   = sync_q[SYNC_STAGES-1];
          rvalid_d  = 1'b1;
          accept_ok = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        oe_d    = 1'b0;
      end
    endcase

    // The edge that ends a transaction can also start the next one; write beats read.
    if (accept_ok) begin
      if (iWR) begin
        state_d = StDrive;
        cnt_d   = HoldLoad;
        oe_d    = 1'b1;
        drive_d = iWDATA;
      end else if (iRD) begin
        state_d = StRead;
        cnt_d   = SyncLoad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      oe_q     <= 1'b0;
      drive_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oe_q     <= oe_d;
      drive_q  <= drive_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      sync_q   <= sync_d;
    end
  end

  assign ioDATA  = oe_q ? drive_q : {DATA_WIDTH{1'bz}};
  assign oOE     = oe_q;
  assign oBUSY   = (state_q != StIdle);
  assign oRDATA  = rdata_q;
  assign oRVALID = rvalid_q;
  assign oSYNC   = sync_q[SYNC_STAGES-1];

endmodule
